// File: rtl/burst_arbiter_pkg.sv
// Shared types and constants for the two-requester burst arbiter.
// State encoding, default counter width and one-hot grant values.
package burst_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    XFER    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

  function automatic logic [1:0] gnt_onehot(input logic sel);
    return sel ? GNT_1 : GNT_0;
  endfunction

endpackage

// File: rtl/burst_arbiter_if.sv
// Request/data-path handshake bundle between descriptor sources, data mover and arbiter.
interface burst_arbiter_if
  import burst_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_size;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_size;
  logic             req1_ready;
  logic             data_start;
  logic             beat;
  logic [1:0]       grant;
  logic             last;
  logic             done;

  modport master (
    output req0_valid, req0_size, req1_valid, req1_size, data_start, beat,
    input  req0_ready, req1_ready, grant, last, done
  );

  modport slave (
    input  req0_valid, req0_size, req1_valid, req1_size, data_start, beat,
    output req0_ready, req1_ready, grant, last, done
  );

endinterface

// File: rtl/burst_arbiter_beat_counter.sv
// Load/decrement/hold beat down-counter; tc flags a count of exactly one.
module beat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;

  // Load has priority; the FSM only requests a decrement while count >= 1.
  always_ff @(posedge clock) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= load_value;
    end else if (dec) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == ONE);

endmodule

// File: rtl/burst_arbiter.sv
// Round-robin arbiter granting one shared beat counter to one of two burst requesters.
module burst_arbiter
  import burst_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic           clock,
  input  logic           rst,
  burst_arbiter_if.slave bus
);

  state_t           state_r;
  state_t           state_next_s;
  logic             pri_r;
  logic             pri_next_s;
  logic             served_r;
  logic             served_next_s;
  logic             sel_s;
  logic             load_s;
  logic             dec_s;
  logic             tc_s;
  logic [WIDTH-1:0] load_value_s;

  beat_counter #(.WIDTH(WIDTH)) u_counter (
    .clock      (clock),
    .rst        (rst),
    .load       (load_s),
    .load_value (load_value_s),
    .dec        (dec_s),
    .tc         (tc_s)
  );

  // State, round-robin pointer and current owner registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_r  <= IDLE;
      pri_r    <= 1'b0;
      served_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      pri_r    <= pri_next_s;
      served_r <= served_next_s;
    end
  end

  // Next-state, counter control and combinational handshake outputs.
  always_comb begin
    state_next_s   = state_r;
    pri_next_s     = pri_r;
    served_next_s  = served_r;
    sel_s          = 1'b0;
    load_s         = 1'b0;
    dec_s          = 1'b0;
    load_value_s   = {WIDTH{1'b0}};
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.last       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          sel_s = pri_r;
        end else if (bus.req1_valid) begin
          sel_s = 1'b1;
        end else begin
          sel_s = 1'b0;
        end
        // Readies stay low while reset is asserted so nothing is consumed.
        if ((bus.req0_valid || bus.req1_valid) && !rst) begin
          load_s         = 1'b1;
          load_value_s   = sel_s ? bus.req1_size : bus.req0_size;
          served_next_s  = sel_s;
          bus.req0_ready = !sel_s;
          bus.req1_ready = sel_s;
          if (load_value_s == {WIDTH{1'b0}}) begin
            state_next_s = DONE;
          end else begin
            state_next_s = WAIT_DS;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT_DS: begin
        if (bus.data_start) begin
          state_next_s = XFER;
        end else begin
          state_next_s = WAIT_DS;
        end
      end
      XFER: begin
        dec_s    = bus.beat;
        bus.last = bus.beat && tc_s && !rst;
        if (bus.beat && tc_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = XFER;
        end
      end
      DONE: begin
        pri_next_s   = !served_r;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Grant and done are pure decodes of the registered state.
  always_comb begin
    case (state_r)
      WAIT_DS, XFER: bus.grant = gnt_onehot(served_r);
      default:       bus.grant = GNT_NONE;
    endcase
    bus.done = (state_r == DONE);
  end

endmodule
